riscv_pipe_cpu: RTL and testbench

- 5-stage pipelined RV32I-subset core: IF, ID, EX, MEM, WB.
- Includes a hazard unit with EX-stage forwarding, a one-cycle load-use stall and branch/jump flushing.
- Connects to an external combined instruction/data memory (cpu_mem) through separate instruction and data ports.
- Sits at the top of the CPU subsystem; the memory is external to this block.

---
 rtl/riscv_pipe_cpu.sv | 265 ++++++++++++++++++++++++++
 tb/tb_riscv_pipe_cpu.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_cpu.sv
// 5-stage RV32I-subset core (IF/ID/EX/MEM/WB): EX forwarding, load-use stall, EX branch flush.
// Define CPU_HAZARD_STATS_EN to add the stall_cnt / flush_cnt hazard counters.

module riscv_pipe_rf (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) regs[wa] <= wd;
  end

  // Write-first: ID sees the value retiring from WB in the same cycle
  always_comb begin
    rdata1 = (ra1 == 5'd0) ? 32'h0 : (we && wa == ra1) ? wd : regs[ra1];
    rdata2 = (ra2 == 5'd0) ? 32'h0 : (we && wa == ra2) ? wd : regs[ra2];
  end
endmodule

module riscv_pipe_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] d_rd,
  output logic [31:0] d_addr,
  output logic        d_we,
  output logic [31:0] d_wd,
  output logic [1:0]  d_dt,
  output logic [31:0] pc
`ifdef CPU_HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR  = 4'd3,
                         A_XOR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7,
                         A_SRL = 4'd8, A_SRA = 4'd9, A_LUI = 4'd10;

  typedef struct packed {
    logic        rw, mr, mw, beq, bne, jal, use_imm;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc, r1, r2;
  } idex_t;

  typedef struct packed {
    logic        rw, mr, mw;
    logic [4:0]  rd;
    logic [31:0] res, wd;
  } exmem_t;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
  } memwb_t;

  logic [31:0] pc_q, pc_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] ifid_ins_q, ifid_ins_d, ifid_pc_q, ifid_pc_d;
  idex_t       idex_q, idex_d, dec;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [31:0] rf_r1, rf_r2;
  logic        rf_we;
  logic        use1, use2, load_use, taken;
  logic [31:0] src_a, src_b, alu_b, alu_y, target;

  assign rf_we = memwb_q.rw && memwb_q.rd != 5'd0;

  riscv_pipe_rf rf (
    .clk(clk), .we(rf_we), .wa(memwb_q.rd), .wd(memwb_q.res),
    .ra1(ifid_ins_q[19:15]), .ra2(ifid_ins_q[24:20]),
    .rdata1(rf_r1), .rdata2(rf_r2)
  );

  // ID: decode into ID/EX control; unsupported encodings leave everything cleared
  always_comb begin
    logic [31:0] i;
    i = ifid_ins_q;
    dec = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    dec.pc = ifid_pc_q;
    dec.rd = i[11:7];
    dec.rs1 = i[19:15];
    dec.rs2 = i[24:20];
    dec.r1 = rf_r1;
    dec.r2 = rf_r2;
    if (ifid_vld_q) begin
      case (i[6:0])
        7'h33: begin
          dec.rw = 1'b1; use1 = 1'b1; use2 = 1'b1;
          case ({i[31:25], i[14:12]})
            10'h000: dec.op = A_ADD;
            10'h001: dec.op = A_SLL;
            10'h002: dec.op = A_SLT;
            10'h003: dec.op = A_SLTU;
            10'h004: dec.op = A_XOR;
            10'h005: dec.op = A_SRL;
            10'h006: dec.op = A_OR;
            10'h007: dec.op = A_AND;
            10'h100: dec.op = A_SUB;
            10'h105: dec.op = A_SRA;
            default: begin dec.rw = 1'b0; use1 = 1'b0; use2 = 1'b0; end
          endcase
        end
        7'h13: begin
          dec.rw = 1'b1; use1 = 1'b1; dec.use_imm = 1'b1;
          dec.imm = {{20{i[31]}}, i[31:20]};
          case (i[14:12])
            3'd0: dec.op = A_ADD;
            3'd2: dec.op = A_SLT;
            3'd4: dec.op = A_XOR;
            3'd6: dec.op = A_OR;
            3'd7: dec.op = A_AND;
            default: begin dec.rw = 1'b0; use1 = 1'b0; end
          endcase
        end
        7'h03: if (i[14:12] == 3'd2) begin
          dec.rw = 1'b1; dec.mr = 1'b1; use1 = 1'b1; dec.use_imm = 1'b1;
          dec.imm = {{20{i[31]}}, i[31:20]};
        end
        7'h23: if (i[14:12] == 3'd2) begin
          dec.mw = 1'b1; use1 = 1'b1; use2 = 1'b1; dec.use_imm = 1'b1;
          dec.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        end
        7'h37: begin
          dec.rw = 1'b1; dec.use_imm = 1'b1; dec.op = A_LUI;
          dec.imm = {i[31:12], 12'h0};
        end
        7'h63: if (i[14:13] == 2'd0) begin
          dec.beq = ~i[12]; dec.bne = i[12]; use1 = 1'b1; use2 = 1'b1;
          dec.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        end
        7'h6f: begin
          dec.rw = 1'b1; dec.jal = 1'b1;
          dec.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign load_use = idex_q.mr && idex_q.rd != 5'd0 &&
                    ((use1 && dec.rs1 == idex_q.rd) || (use2 && dec.rs2 == idex_q.rd));

  // EX: operand forwarding, MEM result has priority over WB
  always_comb begin
    if (exmem_q.rw && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1) src_a = exmem_q.res;
    else if (memwb_q.rw && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) src_a = memwb_q.res;
    else src_a = idex_q.r1;
    if (exmem_q.rw && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2) src_b = exmem_q.res;
    else if (memwb_q.rw && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) src_b = memwb_q.res;
    else src_b = idex_q.r2;
    alu_b = idex_q.use_imm ? idex_q.imm : src_b;
    case (idex_q.op)
      A_SUB:   alu_y = src_a - alu_b;
      A_AND:   alu_y = src_a & alu_b;
      A_OR:    alu_y = src_a | alu_b;
      A_XOR:   alu_y = src_a ^ alu_b;
      A_SLT:   alu_y = {31'h0, $signed(src_a) < $signed(alu_b)};
      A_SLTU:  alu_y = {31'h0, src_a < alu_b};
      A_SLL:   alu_y = src_a << alu_b[4:0];
      A_SRL:   alu_y = src_a >> alu_b[4:0];
      A_SRA:   alu_y = $unsigned($signed(src_a) >>> alu_b[4:0]);
      A_LUI:   alu_y = alu_b;
      default: alu_y = src_a + alu_b;
    endcase
    taken = idex_q.jal || (idex_q.beq && src_a == src_b) || (idex_q.bne && src_a != src_b);
    target = idex_q.pc + idex_q.imm;
  end

  // Next-state: a taken branch flushes IF/ID and ID/EX and overrides any stall
  always_comb begin
    pc_d = pc_q + 32'd4;
    ifid_vld_d = 1'b1;
    ifid_ins_d = instr;
    ifid_pc_d = pc_q;
    idex_d = dec;
    if (taken) begin
      pc_d = target;
      ifid_vld_d = 1'b0;
      ifid_ins_d = '0;
      ifid_pc_d = '0;
      idex_d = '0;
    end else if (load_use) begin
      pc_d = pc_q;
      ifid_vld_d = ifid_vld_q;
      ifid_ins_d = ifid_ins_q;
      ifid_pc_d = ifid_pc_q;
      idex_d = '0;
    end
    exmem_d.rw = idex_q.rw;
    exmem_d.mr = idex_q.mr;
    exmem_d.mw = idex_q.mw;
    exmem_d.rd = idex_q.rd;
    exmem_d.res = idex_q.jal ? idex_q.pc + 32'd4 : alu_y;
    exmem_d.wd = src_b;
    memwb_d.rw = exmem_q.rw;
    memwb_d.rd = exmem_q.rd;
    memwb_d.res = exmem_q.mr ? d_rd : exmem_q.res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ifid_vld_q <= 1'b0;
      ifid_ins_q <= '0;
      ifid_pc_q  <= '0;
      idex_q     <= '0;
      exmem_q    <= '0;
      memwb_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      ifid_vld_q <= ifid_vld_d;
      ifid_ins_q <= ifid_ins_d;
      ifid_pc_q  <= ifid_pc_d;
      idex_q     <= idex_d;
      exmem_q    <= exmem_d;
      memwb_q    <= memwb_d;
    end
  end

  assign pc     = pc_q;
  assign d_addr = exmem_q.res;
  assign d_we   = exmem_q.mw;
  assign d_wd   = exmem_q.wd;
  assign d_dt   = 2'd2;

`ifdef CPU_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_use && !taken && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (taken && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_riscv_pipe_cpu.sv
// Scoreboard bench for riscv_pipe_cpu: ISA-level model predicts register writes and stores,
// a negedge monitor pops and compares them as the core retires.
module tb_riscv_pipe_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr, d_rd, d_addr, d_wd, pc;
  logic        d_we;
  logic [1:0]  d_dt;
`ifdef CPU_HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  riscv_pipe_cpu dut (
    .clk(clk), .rst(rst), .instr(instr), .d_rd(d_rd), .d_addr(d_addr),
    .d_we(d_we), .d_wd(d_wd), .d_dt(d_dt), .pc(pc)
`ifdef CPU_HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Combined memory: words 0..191 program (nop-filled), 192..255 data
  logic [31:0] mem [256];
  assign instr = mem[pc[9:2]];
  assign d_rd  = mem[d_addr[9:2]];
  always @(posedge clk) if (d_we) mem[d_addr[9:2]] <= d_wd;

  typedef struct { int k; int sub; logic [4:0] rd, rs1, rs2; logic [31:0] imm; } op_t;
  typedef struct { logic [31:0] a; logic [31:0] v; int e; } ent_t;

  ent_t        exp_wr[$], exp_st[$];
  op_t         prog [64];
  logic [31:0] r [32];
  logic [31:0] mm [256];
  int          checks = 0, failures = 0, wr_in_reset = 0, cyc = 0;
  int          fr3 [10] = '{0, 0, 7, 6, 4, 2, 3, 1, 5, 5};
  int          fi3 [5]  = '{0, 7, 6, 4, 2};
  int          imap [5] = '{0, 2, 3, 4, 5};

  always @(posedge clk or negedge rst) cyc <= rst ? cyc + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(int k, int sub, int rd, int rs1, int rs2, logic [31:0] imm);
    op_t o;
    o.k = k; o.sub = sub; o.rd = 5'(rd); o.rs1 = 5'(rs1); o.rs2 = 5'(rs2); o.imm = imm;
    return o;
  endfunction

  function automatic logic [31:0] enc(op_t o);
    logic [12:0] b; logic [20:0] j; logic [11:0] s;
    b = o.imm[12:0]; j = o.imm[20:0]; s = o.imm[11:0];
    case (o.k)
      0: return {(o.sub == 1 || o.sub == 9) ? 7'h20 : 7'h00, o.rs2, o.rs1, 3'(fr3[o.sub]), o.rd, 7'h33};
      1: return {s, o.rs1, 3'(fi3[o.sub]), o.rd, 7'h13};
      2: return {s, o.rs1, 3'b010, o.rd, 7'h03};
      3: return {s[11:5], o.rs2, o.rs1, 3'b010, s[4:0], 7'h23};
      4: return {o.imm[31:12], o.rd, 7'h37};
      5, 6: return {b[12], b[10:5], o.rs2, o.rs1, (o.k == 6) ? 3'b001 : 3'b000, b[4:1], b[11], 7'h63};
      7: return {j[20], j[10:1], j[11], j[19:12], o.rd, 7'h6f};
      default: return {o.imm[24:0], 7'h0F};
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(int s, logic [31:0] a, logic [31:0] b);
    case (s)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      7: return a << b[4:0];
      8: return a >> b[4:0];
      default: return $unsigned($signed(a) >>> b[4:0]);
    endcase
  endfunction

  task automatic push_wr(input int rd, input logic [31:0] v, input int e);
    ent_t x; x.a = rd; x.v = v; x.e = e; exp_wr.push_back(x);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] v, input int e);
    ent_t x; x.a = a; x.v = v; x.e = e; exp_st.push_back(x);
  endtask

  // Architectural model: sequential execution, one instruction at a time
  task automatic run_model(input int n);
    int i, nx;
    logic [31:0] v;
    i = 0;
    while (i < n) begin
      nx = i + 1;
      v = 32'h0;
      case (prog[i].k)
        0: v = ref_alu(prog[i].sub, r[prog[i].rs1], r[prog[i].rs2]);
        1: v = ref_alu(imap[prog[i].sub], r[prog[i].rs1], prog[i].imm);
        2: v = mm[prog[i].imm[9:2]];
        3: begin mm[prog[i].imm[9:2]] = r[prog[i].rs2]; push_st(prog[i].imm, r[prog[i].rs2], -1); end
        4: v = prog[i].imm;
        5: if (r[prog[i].rs1] == r[prog[i].rs2]) nx = i + prog[i].imm / 4;
        6: if (r[prog[i].rs1] != r[prog[i].rs2]) nx = i + prog[i].imm / 4;
        7: begin v = 4 * i + 4; nx = i + prog[i].imm / 4; end
        default: ;
      endcase
      if (prog[i].k inside {0, 1, 2, 4, 7} && prog[i].rd != 5'd0) begin
        r[prog[i].rd] = v;
        push_wr(prog[i].rd, v, -1);
      end
      i = nx;
    end
  endtask

  task automatic begin_test();
    rst = 1'b0;
    @(negedge clk);
    exp_wr.delete();
    exp_st.delete();
    wr_in_reset = 0;
    r[0] = 32'h0;
    for (int i = 1; i < 32; i++) r[i] = $urandom;
    for (int i = 0; i < 256; i++) mem[i] = (i >= 192) ? $urandom : 32'h0000_0013;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) mem[i] = enc(prog[i]);
  endtask

  task automatic go(input int ncyc);
    for (int i = 1; i < 32; i++) dut.rf.regs[i] = r[i];
    @(negedge clk);
    rst = 1'b1;
    repeat (ncyc) @(negedge clk);
    #1;
    chk("drain_wr", exp_wr.size(), 0);
    chk("drain_st", exp_st.size(), 0);
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      if (dut.rf.we) wr_in_reset++;
    end else begin
      if (dut.rf.we) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_wr got x%0d=%h want none", dut.rf.wa, dut.rf.wd);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_rd", 32'(dut.rf.wa), e.a);
          chk("wr_val", dut.rf.wd, e.v);
          if (e.e >= 0) chk("wr_edge", cyc + 1, e.e);
        end
      end
      if (d_we) begin
        if (exp_st.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_st got [%h]=%h want none", d_addr, d_wd);
        end else begin
          e = exp_st.pop_front();
          chk("st_addr", d_addr, e.a);
          chk("st_data", d_wd, e.v);
          chk("st_dt", 32'(d_dt), 32'd2);
          if (e.e >= 0) chk("st_edge", cyc + 1, e.e);
        end
      end
    end
  end

  initial begin
    // Reset state
    begin_test();
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_we", 32'(d_we), 0);
    chk("rst_addr", d_addr, 0);
    chk("rst_wd", d_wd, 0);
    chk("rst_dt", 32'(d_dt), 2);

    // Load-use stall: lw x1; and x3,x1,x2; or x4,x5,x1; sub x6,x1,x7
    begin_test();
    r[2] = 3; r[5] = 7; r[7] = 1; mem[192] = 32'hdeadc0de;
    prog[0] = mk(2, 0, 1, 0, 0, 768);
    prog[1] = mk(0, 2, 3, 1, 2, 0);
    prog[2] = mk(0, 3, 4, 5, 1, 0);
    prog[3] = mk(0, 1, 6, 1, 7, 0);
    load_prog(4);
    push_wr(1, 32'hdeadc0de, 5);
    push_wr(3, 32'h2, 7);
    push_wr(4, 32'hdeadc0df, 8);
    push_wr(6, 32'hdeadc0dd, 9);
    go(20);

    // Load then independent ALU writing same rd, consumer takes the younger (MEM) value
    begin_test();
    r[2] = 3; r[3] = 5; mem[192] = 32'hdeadc0de;
    prog[0] = mk(2, 0, 1, 0, 0, 768);
    prog[1] = mk(0, 0, 1, 2, 3, 0);
    prog[2] = mk(0, 0, 4, 1, 2, 0);
    load_prog(3);
    push_wr(1, 32'hdeadc0de, 5);
    push_wr(1, 32'd8, -1);
    push_wr(4, 32'd11, -1);
    go(20);

    // Back-to-back ALU forwarding
    begin_test();
    prog[0] = mk(1, 0, 1, 0, 0, 5);
    prog[1] = mk(0, 0, 2, 1, 1, 0);
    prog[2] = mk(0, 0, 3, 2, 1, 0);
    load_prog(3);
    push_wr(1, 32'd5, 5);
    push_wr(2, 32'd10, 6);
    push_wr(3, 32'd15, 7);
    go(20);

    // Store with forwarded data
    begin_test();
    prog[0] = mk(1, 0, 1, 0, 0, 32'h55);
    prog[1] = mk(3, 0, 0, 0, 1, 4);
    load_prog(2);
    push_wr(1, 32'h55, 5);
    push_st(32'd4, 32'h55, 5);
    go(20);
    chk("st_mem1", mem[1], 32'h55);

    // Taken beq skips the next instruction
    begin_test();
    r[1] = 32'h0000abcd;
    prog[0] = mk(5, 0, 0, 0, 0, 8);
    prog[1] = mk(1, 0, 1, 0, 0, 1);
    prog[2] = mk(1, 0, 2, 0, 0, 2);
    load_prog(3);
    push_wr(2, 32'd2, 8);
    go(20);
    chk("beq_x1", dut.rf.regs[1], 32'h0000abcd);

    // Reset asserted while a store sits in MEM
    begin_test();
    mem[193] = 32'h12345678;
    prog[0] = mk(3, 0, 0, 0, 0, 772);
    load_prog(1);
    for (int i = 1; i < 32; i++) dut.rf.regs[i] = r[i];
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_we", 32'(d_we), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_we", 32'(d_we), 0);
    chk("mid_rst_addr", d_addr, 0);
    chk("mid_rst_wd", d_wd, 0);
    chk("mid_rst_dt", 32'(d_dt), 2);
    repeat (4) @(negedge clk);
    #1;
    chk("mid_rst_wr", wr_in_reset, 0);
    chk("mid_rst_mem", mem[193], 32'h12345678);

    // Randomized programs against the architectural model
    for (int t = 0; t < 6; t++) begin
      begin_test();
      for (int i = 0; i < 256; i++) mm[i] = mem[i];
      for (int i = 0; i < 40; i++) begin
        int p;
        op_t o;
        p = $urandom_range(0, 99);
        o = mk(0, 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
        if (p < 30) begin o.k = 0; o.sub = $urandom_range(0, 9); end
        else if (p < 50) begin
          o.k = 1; o.sub = $urandom_range(0, 4);
          o.imm = $urandom_range(0, 4095);
          o.imm = {{20{o.imm[11]}}, o.imm[11:0]};
        end
        else if (p < 62) begin o.k = 2; o.rs1 = 0; o.imm = 768 + 4 * $urandom_range(0, 63); end
        else if (p < 72) begin o.k = 3; o.rs1 = 0; o.imm = 768 + 4 * $urandom_range(0, 63); end
        else if (p < 77) begin o.k = 4; o.imm = $urandom & 32'hFFFF_F000; end
        else if (p < 84) begin o.k = 5; o.imm = 4 * $urandom_range(2, 4); end
        else if (p < 91) begin o.k = 6; o.imm = 4 * $urandom_range(2, 4); end
        else if (p < 95) begin o.k = 7; o.imm = 4 * $urandom_range(2, 3); end
        else begin o.k = 8; o.imm = $urandom; end
        prog[i] = o;
      end
      load_prog(40);
      for (int i = 1; i < 32; i++) dut.rf.regs[i] = r[i];
      run_model(40);
      // go() reloads regs from r[], which the model has advanced; restore initial values first
      for (int i = 1; i < 32; i++) r[i] = dut.rf.regs[i];
      go(150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
